mem_arbiter: RTL and testbench

Single-outstanding request arbiter that shares the byte-sequencing memory controller's one request port between the instruction fetcher and the load/store unit. It captures one request per requester and grants by priority: LSU first, with a starvation guard for fetch. It issues one pulse-handshaked transaction at a time downstream and routes the response back to the owner. On a pipeline rollback it discards speculative fetch and load traffic but never drops a store.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, rollback and downstream memory signals of the arbiter
interface mem_arbiter_if;
  // instruction fetcher side
  logic        en_signal_from_fetcher;
  logic [31:0] pc_from_fetcher;
  logic        ok_flag_to_fetcher;
  logic [31:0] inst_to_fetcher;
  // load/store unit side
  logic        en_signal_from_lsu;
  logic        rw_flag_from_lsu;
  logic [31:0] addr_from_lsu;
  logic [31:0] write_data_from_lsu;
  logic [2:0]  size_from_lsu;
  logic        ok_flag_to_lsu;
  logic [31:0] load_data_to_lsu;
  // rollback
  logic        drop_flag_from_rob;
  // downstream memory controller port
  logic        en_signal_to_mem;
  logic        rw_flag_to_mem;
  logic [31:0] addr_to_mem;
  logic [31:0] write_data_to_mem;
  logic [2:0]  size_to_mem;
  logic        ok_flag_from_mem;
  logic [31:0] data_from_mem;

  // arbiter view
  modport slave (
    input  en_signal_from_fetcher, pc_from_fetcher,
    output ok_flag_to_fetcher, inst_to_fetcher,
    input  en_signal_from_lsu, rw_flag_from_lsu, addr_from_lsu, write_data_from_lsu, size_from_lsu,
    output ok_flag_to_lsu, load_data_to_lsu,
    input  drop_flag_from_rob,
    output en_signal_to_mem, rw_flag_to_mem, addr_to_mem, write_data_to_mem, size_to_mem,
    input  ok_flag_from_mem, data_from_mem
  );

  // environment view (requesters, rob and memory controller)
  modport master (
    output en_signal_from_fetcher, pc_from_fetcher,
    input  ok_flag_to_fetcher, inst_to_fetcher,
    output en_signal_from_lsu, rw_flag_from_lsu, addr_from_lsu, write_data_from_lsu, size_from_lsu,
    input  ok_flag_to_lsu, load_data_to_lsu,
    output drop_flag_from_rob,
    input  en_signal_to_mem, rw_flag_to_mem, addr_to_mem, write_data_to_mem, size_to_mem,
    output ok_flag_from_mem, data_from_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding fetch/LSU arbiter with starvation guard and rollback drain
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BUSY_FETCH = 3'd1,
    BUSY_LOAD  = 3'd2,
    BUSY_STORE = 3'd3,
    DRAIN      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  // capture slots
  logic          f_vld_q, f_vld_d;
  logic [31:0]   f_pc_q, f_pc_d;
  logic          l_vld_q, l_vld_d;
  logic          l_rw_q, l_rw_d;
  logic [31:0]   l_addr_q, l_addr_d;
  logic [31:0]   l_wdata_q, l_wdata_d;
  logic [2:0]    l_size_q, l_size_d;
  logic [CW-1:0] starve_q, starve_d;
  // registered downstream outputs
  logic          mem_en_q, mem_en_d;
  logic          mem_rw_q, mem_rw_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_size_q, mem_size_d;
  // registered responses
  logic          fetch_ok_q, fetch_ok_d;
  logic [31:0]   fetch_inst_q, fetch_inst_d;
  logic          lsu_ok_q, lsu_ok_d;
  logic [31:0]   lsu_rdata_q, lsu_rdata_d;

  // merged view of slot contents and same-cycle requests after rollback filtering
  logic          drop;
  logic          f_keep, f_take, f_avail;
  logic [31:0]   f_pc_sel;
  logic          l_keep, l_take, l_avail;
  logic          l_rw_sel;
  logic [31:0]   l_addr_sel, l_wdata_sel;
  logic [2:0]    l_size_sel;
  logic          lsu_wins;

  // next-state, slot capture, arbitration and response routing
  always_comb begin
    state_d      = state_q;
    f_vld_d      = f_vld_q;
    f_pc_d       = f_pc_q;
    l_vld_d      = l_vld_q;
    l_rw_d       = l_rw_q;
    l_addr_d     = l_addr_q;
    l_wdata_d    = l_wdata_q;
    l_size_d     = l_size_q;
    starve_d     = starve_q;
    mem_en_d     = 1'b0;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_size_d   = mem_size_q;
    fetch_ok_d   = 1'b0;
    fetch_inst_d = fetch_inst_q;
    lsu_ok_d     = 1'b0;
    lsu_rdata_d  = lsu_rdata_q;

    drop        = bus.drop_flag_from_rob;
    // a rollback kills speculative fetches and loads; stores always survive
    f_keep      = f_vld_q && !drop;
    f_take      = bus.en_signal_from_fetcher && !f_vld_q && (state_q != BUSY_FETCH) && !drop;
    f_avail     = f_keep || f_take;
    f_pc_sel    = f_vld_q ? f_pc_q : bus.pc_from_fetcher;
    l_keep      = l_vld_q && !(drop && !l_rw_q);
    l_take      = bus.en_signal_from_lsu && !l_vld_q
                  && (state_q != BUSY_LOAD) && (state_q != BUSY_STORE)
                  && !(drop && !bus.rw_flag_from_lsu);
    l_avail     = l_keep || l_take;
    l_rw_sel    = l_vld_q ? l_rw_q    : bus.rw_flag_from_lsu;
    l_addr_sel  = l_vld_q ? l_addr_q  : bus.addr_from_lsu;
    l_wdata_sel = l_vld_q ? l_wdata_q : bus.write_data_from_lsu;
    l_size_sel  = l_vld_q ? l_size_q  : bus.size_from_lsu;
    lsu_wins    = l_avail && !((starve_q == STARVE_MAX) && f_avail);

    if (rdy_in) begin
      f_vld_d   = f_avail;
      f_pc_d    = f_pc_sel;
      l_vld_d   = l_avail;
      l_rw_d    = l_rw_sel;
      l_addr_d  = l_addr_sel;
      l_wdata_d = l_wdata_sel;
      l_size_d  = l_size_sel;
      // the guard only counts while a fetch is actually waiting
      starve_d  = f_avail ? starve_q : '0;

      case (state_q)
        IDLE: begin
          if (!drop) begin
            if (lsu_wins) begin
              l_vld_d     = 1'b0;
              mem_en_d    = 1'b1;
              mem_rw_d    = l_rw_sel;
              mem_addr_d  = l_addr_sel;
              mem_wdata_d = l_wdata_sel;
              mem_size_d  = l_size_sel;
              state_d     = l_rw_sel ? BUSY_STORE : BUSY_LOAD;
              if (f_avail && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + CW'(1);
              end
            end else if (f_avail) begin
              f_vld_d     = 1'b0;
              mem_en_d    = 1'b1;
              mem_rw_d    = 1'b0;
              mem_addr_d  = f_pc_sel;
              mem_wdata_d = 32'h0;
              mem_size_d  = 3'd4;
              state_d     = BUSY_FETCH;
              starve_d    = '0;
            end
          end
        end
        BUSY_FETCH: begin
          if (drop) begin
            state_d = bus.ok_flag_from_mem ? IDLE : DRAIN;
          end else if (bus.ok_flag_from_mem) begin
            fetch_ok_d   = 1'b1;
            fetch_inst_d = bus.data_from_mem;
            state_d      = IDLE;
          end
        end
        BUSY_LOAD: begin
          if (drop) begin
            state_d = bus.ok_flag_from_mem ? IDLE : DRAIN;
          end else if (bus.ok_flag_from_mem) begin
            lsu_ok_d    = 1'b1;
            lsu_rdata_d = bus.data_from_mem;
            state_d     = IDLE;
          end
        end
        BUSY_STORE: begin
          if (bus.ok_flag_from_mem) begin
            lsu_ok_d    = 1'b1;
            lsu_rdata_d = 32'h0;
            state_d     = IDLE;
          end
        end
        DRAIN: begin
          // the killed transaction still has to complete downstream; its data is thrown away
          if (bus.ok_flag_from_mem) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, slot and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      f_vld_q      <= 1'b0;
      f_pc_q       <= 32'h0;
      l_vld_q      <= 1'b0;
      l_rw_q       <= 1'b0;
      l_addr_q     <= 32'h0;
      l_wdata_q    <= 32'h0;
      l_size_q     <= 3'd0;
      starve_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_size_q   <= 3'd0;
      fetch_ok_q   <= 1'b0;
      fetch_inst_q <= 32'h0;
      lsu_ok_q     <= 1'b0;
      lsu_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      f_vld_q      <= f_vld_d;
      f_pc_q       <= f_pc_d;
      l_vld_q      <= l_vld_d;
      l_rw_q       <= l_rw_d;
      l_addr_q     <= l_addr_d;
      l_wdata_q    <= l_wdata_d;
      l_size_q     <= l_size_d;
      starve_q     <= starve_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_size_q   <= mem_size_d;
      fetch_ok_q   <= fetch_ok_d;
      fetch_inst_q <= fetch_inst_d;
      lsu_ok_q     <= lsu_ok_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign bus.en_signal_to_mem   = mem_en_q;
  assign bus.rw_flag_to_mem     = mem_rw_q;
  assign bus.addr_to_mem        = mem_addr_q;
  assign bus.write_data_to_mem  = mem_wdata_q;
  assign bus.size_to_mem        = mem_size_q;
  assign bus.ok_flag_to_fetcher = fetch_ok_q;
  assign bus.inst_to_fetcher    = fetch_inst_q;
  assign bus.ok_flag_to_lsu     = lsu_ok_q;
  assign bus.load_data_to_lsu   = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cnt;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(2)) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en_signal_from_fetcher = 1'b0;
    bus.pc_from_fetcher        = 32'h0;
    bus.en_signal_from_lsu     = 1'b0;
    bus.rw_flag_from_lsu       = 1'b0;
    bus.addr_from_lsu          = 32'h0;
    bus.write_data_from_lsu    = 32'h0;
    bus.size_from_lsu          = 3'd0;
    bus.drop_flag_from_rob     = 1'b0;
    bus.ok_flag_from_mem       = 1'b0;
    bus.data_from_mem          = 32'h0;
  endtask

  task automatic lsu_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] sz);
    bus.en_signal_from_lsu  = 1'b1;
    bus.rw_flag_from_lsu    = rw;
    bus.addr_from_lsu       = addr;
    bus.write_data_from_lsu = wd;
    bus.size_from_lsu       = sz;
  endtask

  task automatic mem_ok(input logic [31:0] d);
    bus.ok_flag_from_mem = 1'b1;
    bus.data_from_mem    = d;
    tick();
    bus.ok_flag_from_mem = 1'b0;
  endtask

  initial begin
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_en",    32'(bus.en_signal_to_mem), 32'h0);
    chk("rst_okf",   32'(bus.ok_flag_to_fetcher), 32'h0);
    chk("rst_okl",   32'(bus.ok_flag_to_lsu), 32'h0);
    chk("rst_state", 32'(u_dut.state_q), 32'h0);

    // lone fetch
    bus.en_signal_from_fetcher = 1'b1;
    bus.pc_from_fetcher        = 32'h0000_0100;
    tick();
    bus.en_signal_from_fetcher = 1'b0;
    chk("t1_en",   32'(bus.en_signal_to_mem), 32'h1);
    chk("t1_addr", bus.addr_to_mem, 32'h100);
    chk("t1_size", 32'(bus.size_to_mem), 32'h4);
    chk("t1_rw",   32'(bus.rw_flag_to_mem), 32'h0);
    tick();
    chk("t1_en_pulse", 32'(bus.en_signal_to_mem), 32'h0);
    chk("t1_addr_hold", bus.addr_to_mem, 32'h100);
    tick();
    mem_ok(32'h00A0_0093);
    chk("t1_okf",  32'(bus.ok_flag_to_fetcher), 32'h1);
    chk("t1_inst", bus.inst_to_fetcher, 32'h00A0_0093);
    chk("t1_okl",  32'(bus.ok_flag_to_lsu), 32'h0);
    tick();
    chk("t1_okf_pulse", 32'(bus.ok_flag_to_fetcher), 32'h0);
    chk("t1_inst_hold", bus.inst_to_fetcher, 32'h00A0_0093);

    // simultaneous fetch and load: load first
    bus.en_signal_from_fetcher = 1'b1;
    bus.pc_from_fetcher        = 32'h200;
    lsu_req(1'b0, 32'h1000, 32'h0, 3'd4);
    tick();
    idle_inputs();
    chk("t2_en1",   32'(bus.en_signal_to_mem), 32'h1);
    chk("t2_addr1", bus.addr_to_mem, 32'h1000);
    tick();
    chk("t2_wait",  32'(bus.en_signal_to_mem), 32'h0);
    mem_ok(32'hDEAD_BEEF);
    chk("t2_okl",   32'(bus.ok_flag_to_lsu), 32'h1);
    chk("t2_ld",    bus.load_data_to_lsu, 32'hDEAD_BEEF);
    chk("t2_bubble", 32'(bus.en_signal_to_mem), 32'h0);
    tick();
    chk("t2_en2",   32'(bus.en_signal_to_mem), 32'h1);
    chk("t2_addr2", bus.addr_to_mem, 32'h200);
    mem_ok(32'h0000_0013);
    chk("t2_inst",  bus.inst_to_fetcher, 32'h13);
    tick();

    // starvation guard, limit 2
    bus.en_signal_from_fetcher = 1'b1;
    bus.pc_from_fetcher        = 32'h300;
    lsu_req(1'b0, 32'h2000, 32'h0, 3'd4);
    tick();
    idle_inputs();
    chk("t3_g1",   bus.addr_to_mem, 32'h2000);
    chk("t3_st1",  32'(u_dut.starve_q), 32'h1);
    mem_ok(32'h11);
    chk("t3_ok1",  32'(bus.ok_flag_to_lsu), 32'h1);
    lsu_req(1'b0, 32'h2004, 32'h0, 3'd4);
    tick();
    idle_inputs();
    chk("t3_en2",  32'(bus.en_signal_to_mem), 32'h1);
    chk("t3_g2",   bus.addr_to_mem, 32'h2004);
    chk("t3_st2",  32'(u_dut.starve_q), 32'h2);
    mem_ok(32'h22);
    lsu_req(1'b0, 32'h2008, 32'h0, 3'd4);
    tick();
    idle_inputs();
    chk("t3_en3",  32'(bus.en_signal_to_mem), 32'h1);
    chk("t3_g3",   bus.addr_to_mem, 32'h300);
    chk("t3_st3",  32'(u_dut.starve_q), 32'h0);
    mem_ok(32'h33);
    chk("t3_okf",  32'(bus.ok_flag_to_fetcher), 32'h1);
    chk("t3_inst", bus.inst_to_fetcher, 32'h33);
    tick();
    chk("t3_g4",   bus.addr_to_mem, 32'h2008);
    chk("t3_en4",  32'(bus.en_signal_to_mem), 32'h1);
    chk("t3_st4",  32'(u_dut.starve_q), 32'h0);
    mem_ok(32'h44);
    chk("t3_ld4",  bus.load_data_to_lsu, 32'h44);
    tick();

    // drop during BUSY_FETCH with a load waiting
    bus.en_signal_from_fetcher = 1'b1;
    bus.pc_from_fetcher        = 32'h400;
    tick();
    idle_inputs();
    chk("t4_addr", bus.addr_to_mem, 32'h400);
    lsu_req(1'b0, 32'h1004, 32'h0, 3'd4);
    tick();
    idle_inputs();
    bus.drop_flag_from_rob = 1'b1;
    tick();
    idle_inputs();
    chk("t4_drain", 32'(u_dut.state_q), 32'h4);
    tick();
    mem_ok(32'h55);
    chk("t4_okf",  32'(bus.ok_flag_to_fetcher), 32'h0);
    chk("t4_okl",  32'(bus.ok_flag_to_lsu), 32'h0);
    chk("t4_inst", bus.inst_to_fetcher, 32'h33);
    chk("t4_idle", 32'(u_dut.state_q), 32'h0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.en_signal_to_mem) cnt++;
    end
    chk("t4_no_issue", 32'(cnt), 32'h0);

    // drop during BUSY_STORE with a fetch waiting
    lsu_req(1'b1, 32'h3_0000, 32'h41, 3'd1);
    tick();
    idle_inputs();
    chk("t5_en",   32'(bus.en_signal_to_mem), 32'h1);
    chk("t5_rw",   32'(bus.rw_flag_to_mem), 32'h1);
    chk("t5_addr", bus.addr_to_mem, 32'h3_0000);
    chk("t5_data", bus.write_data_to_mem, 32'h41);
    chk("t5_size", 32'(bus.size_to_mem), 32'h1);
    bus.en_signal_from_fetcher = 1'b1;
    bus.pc_from_fetcher        = 32'h500;
    tick();
    idle_inputs();
    bus.drop_flag_from_rob = 1'b1;
    tick();
    idle_inputs();
    chk("t5_store", 32'(u_dut.state_q), 32'h3);
    mem_ok(32'h99);
    chk("t5_okl",  32'(bus.ok_flag_to_lsu), 32'h1);
    chk("t5_ld0",  bus.load_data_to_lsu, 32'h0);
    chk("t5_idle", 32'(u_dut.state_q), 32'h0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.en_signal_to_mem) cnt++;
    end
    chk("t5_no_issue", 32'(cnt), 32'h0);

    // rdy_in low after a grant, then reset in BUSY_LOAD
    lsu_req(1'b0, 32'h3000, 32'h0, 3'd2);
    tick();
    idle_inputs();
    chk("t6_en", 32'(bus.en_signal_to_mem), 32'h1);
    rdy = 1'b0;
    bus.ok_flag_from_mem = 1'b1;
    bus.data_from_mem    = 32'h77;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.en_signal_to_mem || bus.ok_flag_to_lsu || bus.ok_flag_to_fetcher) cnt++;
    end
    chk("t6_frozen", 32'(cnt), 32'h0);
    chk("t6_state",  32'(u_dut.state_q), 32'h2);
    rdy = 1'b1;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_en",    32'(bus.en_signal_to_mem), 32'h0);
    chk("t6_rst_addr",  bus.addr_to_mem, 32'h0);
    chk("t6_rst_size",  32'(bus.size_to_mem), 32'h0);
    chk("t6_rst_inst",  bus.inst_to_fetcher, 32'h0);
    chk("t6_rst_ld",    bus.load_data_to_lsu, 32'h0);
    chk("t6_rst_okl",   32'(bus.ok_flag_to_lsu), 32'h0);
    chk("t6_rst_state", 32'(u_dut.state_q), 32'h0);
    bus.en_signal_from_fetcher = 1'b1;
    bus.pc_from_fetcher        = 32'h600;
    tick();
    idle_inputs();
    chk("t6_en2",   32'(bus.en_signal_to_mem), 32'h1);
    chk("t6_addr2", bus.addr_to_mem, 32'h600);
    chk("t6_size2", 32'(bus.size_to_mem), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
